// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU and multiply/divide unit.
package alu_pkg;

  localparam int unsigned MULDIV_N = 32;
  localparam int unsigned CNT_W    = $clog2(MULDIV_N) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at start, iterated N times through one
// shared N+1-bit adder, then sign-corrected in FIX before landing in HI/LO.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned N = MULDIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned AW = N + 2;

  muldiv_state_t state, state_d;

  logic           is_div, is_div_d;
  logic           neg_res, neg_res_d;
  logic           neg_rem, neg_rem_d;
  logic           dvz, dvz_d;
  logic [N-1:0]   opnd, opnd_d;
  logic [2*N-1:0] acc, acc_d;
  logic [N-1:0]   rem, rem_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [N-1:0]   hi_d, lo_d;
  logic           busy_d, done_d;

  logic [N:0]     shifted;
  logic [N:0]     add_x, add_y;
  logic           add_cin;
  logic [AW-1:0]  add_sum;
  logic           carry;

  muldiv_op_t     op_e;
  logic           sgn_op;
  logic           div_op;
  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] prod;

  // Magnitude of x when interpreted as signed (only for signed ops).
  function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic sgn);
    return (sgn && x[N-1]) ? N'(~x + N'(1)) : x;
  endfunction

  // Conditional N-bit two's complement negate.
  function automatic logic [N-1:0] neg_n(input logic [N-1:0] x, input logic n);
    return n ? N'(~x + N'(1)) : x;
  endfunction

  // Conditional 2N-bit two's complement negate.
  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x, input logic n);
    return n ? (2*N)'(~x + (2*N)'(1)) : x;
  endfunction

  // Shared adder: shift-add for multiply, trial subtract for divide.
  always_comb begin
    shifted = {rem, acc[N-1]};
    if (is_div) begin
      add_x   = shifted;
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc[2*N-1:N]};
      add_y   = acc[0] ? {1'b0, opnd} : '0;
      add_cin = 1'b0;
    end
    add_sum = AW'(add_x) + AW'(add_y) + AW'(add_cin);
    carry   = add_sum[N+1];
  end

  // Start-time operand decode.
  always_comb begin
    op_e   = muldiv_op_t'(op);
    sgn_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    div_op = (op_e == OP_DIV) || (op_e == OP_DIVU);
    a_mag  = mag(a, sgn_op);
    b_mag  = mag(b, sgn_op);
    prod   = neg_2n(acc, neg_res);
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d   = state;
    is_div_d  = is_div;
    neg_res_d = neg_res;
    neg_rem_d = neg_rem;
    dvz_d     = dvz;
    opnd_d    = opnd;
    acc_d     = acc;
    rem_d     = rem;
    cnt_d     = cnt;
    hi_d      = hi;
    lo_d      = lo;
    busy_d    = busy;
    done_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          is_div_d  = div_op;
          neg_res_d = sgn_op && (a[N-1] ^ b[N-1]);
          neg_rem_d = sgn_op && a[N-1];
          dvz_d     = (b == '0);
          opnd_d    = div_op ? b_mag : a_mag;
          acc_d     = {N'(0), div_op ? a_mag : b_mag};
          rem_d     = '0;
          cnt_d     = '0;
        end
      end
      RUN: begin
        if (is_div) begin
          // Partial remainder is N+1 bits wide but always settles below the divisor.
          rem_d        = carry ? add_sum[N-1:0] : shifted[N-1:0];
          acc_d[N-1:0] = {acc[N-2:0], carry};
        end else begin
          acc_d = {add_sum[N:0], acc[N-1:1]};
        end
        if (cnt == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = CW'(cnt + CW'(1));
        end
      end
      FIX: begin
        if (is_div) begin
          lo_d = dvz ? '1 : neg_n(acc[N-1:0], neg_res);
          hi_d = neg_n(rem, neg_rem);
        end else begin
          hi_d = prod[2*N-1:N];
          lo_d = prod[N-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Datapath and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dvz     <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      rem     <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      is_div  <= is_div_d;
      neg_res <= neg_res_d;
      neg_rem <= neg_rem_d;
      dvz     <= dvz_d;
      opnd    <= opnd_d;
      acc     <= acc_d;
      rem     <= rem_d;
      cnt     <= cnt_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [N-1:0]  a, b;
  logic          hi_we, lo_we;
  logic [N-1:0]  wdata;
  logic          busy, done;
  logic [N-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from MIPS semantics using 64-bit arithmetic.
  function automatic logic [63:0] ref_muldiv(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00:   return 64'(sx * sy);
      2'b01:   return ux * uy;
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
        end else begin
          q = longint'(ux / uy);
          r = longint'(ux % uy);
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'(int'($urandom_range(0, 255)));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inj_start, input bit inj_mtlo, input bit mthi_same,
                        input string tag);
    logic [63:0] exp;
    int lat;
    bit hold_ok;
    bit seen;
    exp = ref_muldiv(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    if (mthi_same) begin
      hi_we = 1'b1;
      wdata = 32'h0BAD_F00D;
    end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    if (mthi_same) begin
      m_hi = 32'h0BAD_F00D;
      check({tag, ".mthi_same"}, 64'(hi), 64'(m_hi));
    end
    check({tag, ".busy"}, 64'(busy), 64'd1);
    hold_ok = 1'b1;
    seen = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      if (inj_start && lat == 5) begin
        start = 1'b1; op = 2'b01; a = 32'h7; b = 32'h9;
      end
      if (inj_start && lat == 6) start = 1'b0;
      if (inj_mtlo && lat == 8) begin
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (inj_mtlo && lat == 9) lo_we = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy || hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
    end
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(N + 1));
    check({tag, ".hold"}, 64'(hold_ok), 64'd1);
    check({tag, ".hilo"}, {hi, lo}, exp);
    check({tag, ".idle_at_done"}, 64'(busy), 64'd0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "multu_max");
    check("multu_max.const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0, 1'b0, "mult_neg_busy_start");
    check("mult_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_second_done", 64'({busy, done}), 64'd0);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 1'b0, "div_neg");
    check("div_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b0, 1'b0, "divu");
    check("divu.const", {hi, lo}, 64'h0000_0002_0000_000E);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "divu_zero");
    check("divu_zero.const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "div_zero_neg");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "div_ovf");
    check("div_ovf.const", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI/MTLO while idle.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0; m_hi = 32'h1234_5678;
    check("mthi_idle", 64'(hi), 64'h1234_5678);
    lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    lo_we = 1'b0; m_lo = 32'h0F0F_0F0F;
    check("mtlo_idle", 64'(lo), 64'h0F0F_0F0F);

    run_op(2'b00, 32'h0000_1234, 32'hFFFF_0003, 1'b0, 1'b1, 1'b0, "mtlo_busy");
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b1, "mthi_same_edge");

    // Asynchronous reset in the middle of a multiply.
    op = 2'b00; a = 32'h0000_0123; b = 32'h0000_0456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    check("midreset.hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(2'b00, 32'h0000_0123, 32'h0000_0456, 1'b0, 1'b0, 1'b0, "after_reset");

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = pick_val();
      rb = pick_val();
      run_op(ro, ra, rb, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
